// File: rtl/window_buffer_loader.sv
// Streams a raster-order grayscale frame into two line buffers and emits a 3x4
// pixel window, advancing two columns per enable_calc strobe.
module window_buffer_loader #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start_frame,
  input  logic [DATA_W-1:0]        i_pixel_in,
  input  logic                     i_pixel_valid,
  output logic                     o_pixel_ready,
  output logic [11:0][DATA_W-1:0]  o_data_buffer,
  output logic                     o_enable_calc,
  output logic                     o_frame_done,
  output logic                     o_busy
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(3);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

  state_t                   r_state;
  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic                     r_ready;
  logic                     r_busy;
  logic                     r_vld_p1;
  logic                     r_done_p1;
  logic [11:0][DATA_W-1:0]  r_data_p1;

  logic [DATA_W-1:0]        r_lb0 [IMG_WIDTH];
  logic [DATA_W-1:0]        r_lb1 [IMG_WIDTH];
  logic [3:0][DATA_W-1:0]   r_sr0_p0;
  logic [3:0][DATA_W-1:0]   r_sr1_p0;
  logic [3:0][DATA_W-1:0]   r_sr2_p0;

  logic                     w_accept;
  logic                     w_strobe;
  logic                     w_last;
  logic [3:0][DATA_W-1:0]   w_sr0_nxt;
  logic [3:0][DATA_W-1:0]   w_sr1_nxt;
  logic [3:0][DATA_W-1:0]   w_sr2_nxt;
  logic [11:0][DATA_W-1:0]  w_window;

  assign w_accept = i_pixel_valid && r_ready;

  // Element 3 of each row register is the newest column; older columns slide down.
  assign w_sr0_nxt = {r_lb0[r_col], r_sr0_p0[3:1]};
  assign w_sr1_nxt = {r_lb1[r_col], r_sr1_p0[3:1]};
  assign w_sr2_nxt = {i_pixel_in,   r_sr2_p0[3:1]};
  assign w_window  = {w_sr2_nxt, w_sr1_nxt, w_sr0_nxt};

  // Odd columns >= 3 guarantee all four window columns come from the current row.
  assign w_strobe = w_accept && (r_state == RUN) && (r_col >= COL_FIRST_WIN) && r_col[0];
  assign w_last   = w_accept && (r_state == RUN) && (r_row == ROW_LAST) && (r_col == COL_LAST);

  // Stage p0: line buffers and column shift registers
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= i_pixel_in;
      r_sr0_p0     <= w_sr0_nxt;
      r_sr1_p0     <= w_sr1_nxt;
      r_sr2_p0     <= w_sr2_nxt;
    end
  end

  // Stage p1: control FSM and registered window output
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_done_p1 <= 1'b0;
      r_data_p1 <= '0;
    end else begin
      r_vld_p1  <= 1'b0;
      r_done_p1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start_frame) begin
            r_state <= FILL;
            r_col   <= '0;
            r_row   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        FILL, RUN: begin
          if (w_accept) begin
            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
            if (r_state == FILL && r_row == RW'(1) && r_col == COL_LAST) begin
              r_state <= RUN;
            end
            if (w_strobe) begin
              r_vld_p1  <= 1'b1;
              r_data_p1 <= w_window;
            end
            if (w_last) begin
              r_state   <= IDLE;
              r_ready   <= 1'b0;
              r_busy    <= 1'b0;
              r_done_p1 <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_pixel_ready = r_ready;
  assign o_busy        = r_busy;
  assign o_enable_calc = r_vld_p1;
  assign o_frame_done  = r_done_p1;
  assign o_data_buffer = r_data_p1;

endmodule

// File: doc/window_buffer_loader.md
# window_buffer_loader

Streaming producer of the 3-row × 4-column pixel window consumed by the Sobel gx/gy window blocks. Accepts an 8-bit grayscale frame in raster order over a valid/ready handshake, keeps the two previous image rows in internal line buffers, and presents a packed 12-byte `data_buffer` with a one-cycle `enable_calc` strobe. The window advances two columns per strobe, so the window-1 (columns 0–2) and window-2 (columns 1–3) calculators each produce one result per strobe.

## Interface
- `IMG_WIDTH`, 640: pixels per row; even, ≥ 4.
- `IMG_HEIGHT`, 480: rows per frame; ≥ 3.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_frame`  in  1  one-cycle pulse that starts a frame; honored only in IDLE.
- `pixel_in`  in  8  unsigned pixel.
- `pixel_valid`  in  1  `pixel_in` is valid.
- `pixel_ready`  out  1  block accepts a pixel this cycle.
- `data_buffer`  out  12×8 packed `[11:0][7:0]`  window; element index = row*4 + col; row 0 is the oldest (top) row, row 2 is the newest (bottom); col 3 is the newest column.
- `enable_calc`  out  1  one-cycle strobe; `data_buffer` is a new valid window.
- `frame_done`  out  1  one-cycle pulse at the end of the frame.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- A pixel is accepted on a rising edge where `pixel_valid && pixel_ready`. Nothing changes on an edge without acceptance.
- Counters: `col` runs 0..IMG_WIDTH-1 and `row` runs 0..IMG_HEIGHT-1. On an accepted pixel, `col` increments. When `col` wraps to 0, `row` increments.
- Line buffers `lb0` (row r-2) and `lb1` (row r-1) each hold IMG_WIDTH bytes and are not reset. On an accepted pixel at column c:
  - push the column {lb0[c], lb1[c], pixel_in} into a 4-deep column shift register; the new column becomes col 3 and the oldest column is dropped;
  - write lb0[c] ← lb1[c] and lb1[c] ← pixel_in.
- Strobe condition: row ≥ 2, c ≥ 3 and c odd. On that acceptance, register the shift-register contents (including the new column) into `data_buffer` and pulse `enable_calc`.
- Strobe count: (IMG_WIDTH-2)/2 per row and (IMG_WIDTH-2)/2 × (IMG_HEIGHT-2) per frame.
- `data_buffer` holds its value between strobes.
- Columns left over from the previous row are never emitted, because c ≥ 3 guarantees all four columns belong to the current row.
- FSM:
  - IDLE: `pixel_ready`=0. `start_frame` clears the counters and moves to FILL.
  - FILL: rows 0–1; `pixel_ready`=1. Accepting the pixel at (1, W-1) moves to RUN.
  - RUN: rows 2..H-1; `pixel_ready`=1. Accepting the pixel at (H-1, W-1) pulses `frame_done` and returns to IDLE.
- `start_frame` in FILL or RUN is ignored.

## Timing
- Reset values: `pixel_ready`=0, `data_buffer`=0, `enable_calc`=0, `frame_done`=0, `busy`=0. State IDLE, counters 0.
- `rst` takes priority over every other input in the same cycle.
- `rst` mid-frame returns the block to IDLE on that edge. No strobes follow, and a new `start_frame` is required.
- `pixel_ready` is registered and rises the cycle after `start_frame` is sampled in IDLE.
- Latency: `enable_calc` and the new `data_buffer` appear in the cycle after the accepting edge, i.e. one register stage. Downstream registers its result on the following edge.
- Final pixel: `frame_done` asserts in the same cycle as the final `enable_calc`. `pixel_ready` and `busy` drop in that cycle too.
- Back-to-back acceptance at full rate is supported; `pixel_valid` gaps only stretch the timing.
- `pixel_in` is ignored when `pixel_valid`=0 or `pixel_ready`=0.

## Test plan
- Reset, then idle with `pixel_valid`=1 and no `start_frame` -> `pixel_ready`=0, `busy`=0, `enable_calc` never pulses, all outputs 0.
- IMG_WIDTH=8, IMG_HEIGHT=4, pixel value = row*16+col, full rate -> first strobe the cycle after accepting (2,3):
  - `data_buffer[0..3]`=0x00..0x03, `[4..7]`=0x10..0x13, `[8..11]`=0x20..0x23;
  - next strobe two cycles later with 0x02..0x05 / 0x12..0x15 / 0x22..0x25;
  - 6 strobes total;
  - `frame_done` coincides with the strobe carrying 0x34..0x37 in `[8..11]`.
- Same frame with `pixel_valid` toggling on alternate cycles -> identical `data_buffer` sequence and count; each strobe one cycle after its accepting edge.
- `rst` asserted after accepting (2,4) -> next cycle all outputs 0 and IDLE. A new `start_frame` and full frame produces the complete 6-strobe sequence, with no window from the aborted frame.
- `start_frame` pulsed during RUN -> ignored; strobe count and values unchanged. `start_frame` together with `rst` -> block stays IDLE.
- Two frames back to back (`start_frame` the cycle after `frame_done`), second frame = 0xFF - first -> second frame windows contain only second-frame data, 6 strobes.
